// File: rtl/aes_dec_round_fsm.sv
// AES decryption round controller: optional forward key expansion, then inverse
// rounds Nr..0 with per-round datapath controls and a one-cycle done pulse.
module aes_dec_round_fsm #(
  parameter int NR_128 = 10,
  parameter int NR_256 = 14,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_len,
  input  logic             key_new,
  output logic             ready,
  output logic             key_gene_en,
  output logic [CNT_W-1:0] key_wr_addr,
  output logic [CNT_W-1:0] key_rd_addr,
  output logic [CNT_W-1:0] Round_Count,
  output logic             init_round,
  output logic             final_round,
  output logic             round_en,
  output logic             done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_KEYEXP = 2'd1;
  localparam logic [1:0] S_ROUND  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] NR_S = CNT_W'(NR_128);
  localparam logic [CNT_W-1:0] NR_L = CNT_W'(NR_256);

  logic [1:0]       state;
  logic             key_len_q;   // length of the block in flight
  logic             key_len_s;   // length of the key currently held in storage
  logic             key_valid;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rnd_cnt;
  logic [CNT_W-1:0] nr_q;
  logic [CNT_W-1:0] nr_in;
  logic             need_exp;

  assign nr_q     = key_len_q ? NR_L : NR_S;
  assign nr_in    = key_len   ? NR_L : NR_S;
  assign need_exp = key_new || !key_valid || (key_len != key_len_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      key_len_q <= 1'b0;
      key_len_s <= 1'b0;
      key_valid <= 1'b0;
      wr_cnt    <= '0;
      rnd_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            key_len_q <= key_len;
            if (need_exp) begin
              state  <= S_KEYEXP;
              wr_cnt <= CNT_W'(1);
            end else begin
              state   <= S_ROUND;
              rnd_cnt <= nr_in;
            end
          end
        end
        S_KEYEXP: begin
          if (wr_cnt == nr_q) begin
            state     <= S_ROUND;
            wr_cnt    <= '0;
            rnd_cnt   <= nr_q;
            key_valid <= 1'b1;
            key_len_s <= key_len_q;
          end else begin
            wr_cnt <= wr_cnt + CNT_W'(1);
          end
        end
        S_ROUND: begin
          // Counter stops at 0 so it holds there through DONE and IDLE.
          if (rnd_cnt == '0) state <= S_DONE;
          else               rnd_cnt <= rnd_cnt - CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready       = (state == S_IDLE);
  assign key_gene_en = (state == S_KEYEXP);
  assign key_wr_addr = wr_cnt;
  assign Round_Count = rnd_cnt;
  assign key_rd_addr = rnd_cnt;
  assign round_en    = (state == S_ROUND);
  assign init_round  = (state == S_ROUND) && (rnd_cnt == nr_q);
  assign final_round = (state == S_ROUND) && (rnd_cnt == '0);
  assign done        = (state == S_DONE);

endmodule

// File: tb/tb_aes_dec_round_fsm.sv
// Directed bench for aes_dec_round_fsm: expected outputs derived per cycle from
// the cycle index after start acceptance, the key length and whether expansion is due.
module tb_aes_dec_round_fsm;
  logic       clk = 1'b0;
  logic       rst, start, key_len, key_new;
  logic       ready, key_gene_en, init_round, final_round, round_en, done;
  logic [3:0] key_wr_addr, key_rd_addr, Round_Count;
  int         n_chk = 0, n_fail = 0;

  aes_dec_round_fsm dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_new(key_new),
    .ready(ready), .key_gene_en(key_gene_en), .key_wr_addr(key_wr_addr),
    .key_rd_addr(key_rd_addr), .Round_Count(Round_Count), .init_round(init_round),
    .final_round(final_round), .round_en(round_en), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {ready, key_gene_en, key_wr_addr, Round_Count, init, final, round_en, done}
  function automatic logic [13:0] obs();
    return {ready, key_gene_en, key_wr_addr, Round_Count, init_round, final_round, round_en, done};
  endfunction

  // Called at a negedge with the DUT in IDLE. Checks every cycle through done
  // and the IDLE cycle that follows.
  task automatic run_block(input string nm, input logic kl, input logic kn,
                           input bit exp_x, input bit hold, input bit toggle);
    int nr, e, tot;
    logic [3:0] rc, wa;
    logic [13:0] ex;
    nr  = kl ? 14 : 10;
    e   = exp_x ? nr : 0;
    tot = e + nr + 2;
    start = 1'b1; key_len = kl; key_new = kn;
    for (int k = 1; k <= tot; k++) begin
      @(posedge clk); @(negedge clk);
      if (!hold) start = 1'b0;
      if (toggle && k == e + 5) begin key_len = ~kl; key_new = 1'b1; end
      if (k <= e) begin
        wa = 4'(k); rc = 4'd0;
        ex = {1'b0, 1'b1, wa, rc, 4'b0000};
      end else if (k <= e + nr + 1) begin
        rc = 4'(nr - (k - e - 1));
        ex = {1'b0, 1'b0, 4'd0, rc, (k == e + 1), (k == e + nr + 1), 1'b1, 1'b0};
      end else begin
        rc = 4'd0;
        ex = {1'b0, 1'b0, 4'd0, 4'd0, 4'b0001};
      end
      chk($sformatf("%s_c%0d", nm, k), 32'(obs()), 32'(ex));
      if (k > e && k <= e + nr + 1) chk($sformatf("%s_rd%0d", nm, k), 32'(key_rd_addr), 32'(rc));
    end
    @(posedge clk); @(negedge clk);
    chk({nm, "_idle"}, 32'(obs()), 32'({1'b1, 13'd0}));
    key_len = kl; key_new = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_len = 1'b0; key_new = 1'b0;
    // T1 reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_obs", 32'(obs()), 32'({1'b1, 13'd0}));
    chk("rst_rd", 32'(key_rd_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hold", 32'(obs()), 32'({1'b1, 13'd0}));
    // T2 first block expands; T3/T5 reuse with start held and inputs toggled
    run_block("t2", 1'b0, 1'b0, 1, 0, 0);
    run_block("t3", 1'b0, 1'b0, 0, 1, 1);
    run_block("b2b", 1'b0, 1'b0, 0, 0, 0);
    // T4 length switch, then reuse and forced re-expansion
    run_block("t4", 1'b1, 1'b0, 1, 0, 0);
    run_block("t4r", 1'b1, 1'b0, 0, 0, 0);
    run_block("kn", 1'b1, 1'b1, 1, 0, 0);
    // T6 reset mid-round at Round_Count=5 (AES-256 reuse)
    start = 1'b1; key_len = 1'b1; key_new = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 10; k++) begin @(posedge clk); @(negedge clk); end
    chk("t6_rc5", 32'(Round_Count), 32'd5);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t6_rst", 32'(obs()), 32'({1'b1, 13'd0}));
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t6_nodone", 32'(obs()), 32'({1'b1, 13'd0}));
    run_block("t6", 1'b1, 1'b0, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
